axi4_lat_mem_slave: RTL and testbench
=====================================

Name: axi4_lat_mem_slave

Overview:
- Parametrised, synthesizable AXI4 slave memory that succeeds the fixed pseudo DRAM model attached to chip-level PATTERN benches.
- Serves INCR bursts on independent read and write channels.
- Read-data latency and write-response latency are programmable by parameter.
- Supports one outstanding transaction per direction, so benches can stress DUT AXI masters under different DRAM timings.

Parameters:
- ID_WIDTH, 4, width of AXI ID fields.
- DATA_WIDTH, 128, data bus width in bits (power of two, ≥8).
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 1024, number of DATA_WIDTH words stored (power of two).
- RD_LAT, 4, cycles from AR handshake to first R beat valid (≥1).
- WR_LAT, 2, cycles from last W beat accepted to bvalid (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- awid_s_inf  in  ID_WIDTH  write ID.
- awaddr_s_inf  in  ADDR_WIDTH  write start byte address.
- awsize_s_inf  in  3  beat size; ignored, full width assumed.
- awburst_s_inf  in  2  burst type.
- awlen_s_inf  in  8  beats minus one.
- awvalid_s_inf  in  1  AW valid.
- awready_s_inf  out  1  AW ready.
- wdata_s_inf  in  DATA_WIDTH  write data.
- wlast_s_inf  in  1  last W beat.
- wvalid_s_inf  in  1  W valid.
- wready_s_inf  out  1  W ready.
- bid_s_inf  out  ID_WIDTH  response ID.
- bresp_s_inf  out  2  write response.
- bvalid_s_inf  out  1  B valid.
- bready_s_inf  in  1  B ready.
- arid_s_inf  in  ID_WIDTH  read ID.
- araddr_s_inf  in  ADDR_WIDTH  read start byte address.
- arlen_s_inf  in  8  beats minus one.
- arsize_s_inf  in  3  ignored.
- arburst_s_inf  in  2  burst type.
- arvalid_s_inf  in  1  AR valid.
- arready_s_inf  out  1  AR ready.
- rid_s_inf  out  ID_WIDTH  read ID.
- rdata_s_inf  out  DATA_WIDTH  read data.
- rresp_s_inf  out  2  read response.
- rlast_s_inf  out  1  last R beat.
- rvalid_s_inf  out  1  R valid.
- rready_s_inf  in  1  R ready.

Behaviour:
- Reset: all outputs 0, both FSMs to IDLE, counters cleared. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst immediately; valids drop in the same cycle, asynchronously.
- Word index = awaddr/araddr >> log2(DATA_WIDTH/8). Successive beats increment the index, modulo DEPTH (wrap-around).
- Write FSM, IDLE → W_DATA → W_LAT → W_RESP → IDLE:
  - IDLE: awready=1. On awvalid, latch ID, index and length.
  - W_DATA: wready=1. Each wvalid beat writes mem[index] and increments the index.
  - Beat whose count equals awlen+1 → W_LAT. wlast is ignored for termination.
  - W_LAT: counts WR_LAT-1 cycles.
  - W_RESP: bvalid=1, bid=latched ID, bresp=00. Hold until bready, then IDLE.
- Read FSM, IDLE → R_LAT → R_DATA → IDLE:
  - IDLE: arready=1. On arvalid, latch ID, index and length.
  - R_LAT: counts RD_LAT-1 cycles.
  - R_DATA: rvalid=1, rdata=mem[index], rid=latched ID, rresp=00, rlast=1 on beat arlen+1.
  - rdata/rlast/rid stay stable while rvalid && !rready.
  - Beat advances only on rready. After last beat accepted → IDLE.
- With RD_LAT=1, first rvalid is in the cycle after the AR handshake. With WR_LAT=1, bvalid is in the cycle after the last W handshake.
- Read and write bursts may overlap. Same word read and written in the same cycle: read returns the old value; the write takes effect at the clock edge.
- awready/arready are 0 outside IDLE, so a second request stalls until the current burst completes.

Optional Feature:
- AXI_MEM_ERR_CHECK_EN defined:
  - A burst with burst type ≠ 01 (INCR), or whose span crosses beyond DEPTH words, returns SLVERR (10) on bresp / all rresp beats.
  - Writes of that burst are suppressed. Reads return zero data.
- Not defined: no checking, all responses OKAY (00), indices wrap modulo DEPTH.

Test Plan:
- Reset mid-read (rst=1 during beat 3 of 8) → rvalid=0 the same cycle. Next AR is accepted normally with correct data.
- AW addr 0x100, len 3, data 1..4 (bready=1); then AR addr 0x100, len 3, rready=1 → bvalid 2 cycles after 4th W beat; rdata 1,2,3,4; rlast on 4th; first rvalid 4 cycles after AR.
- Read backpressure: len 7, rready toggled 1/0 each cycle → rdata held stable while stalled; 8 beats total, rlast only on 8th.
- Wrap: DEPTH=1024, DATA_WIDTH=128, write len 1 at addr 0x3FF0 → words 1023 then 0 written.
  - With AXI_MEM_ERR_CHECK_EN: bresp=10 and memory unchanged.
- Concurrent AR and AW same cycle, same address → both handshakes in 1 cycle. Read returns pre-write data when its beat precedes the write, new data otherwise.
- Error check (macro on): AR with arburst=00 → all rresp=10, rdata=0, rlast correct.

Source files
------------

// File: rtl/axi4_lat_mem_slave.sv
// AXI4 INCR-burst slave memory with parameterised read-data and write-response latency,
// one outstanding transaction per direction. Define AXI_MEM_ERR_CHECK_EN to return SLVERR on bad bursts.
module axi4_lat_mem_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic [7:0]            awlen_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [7:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf
);

  localparam int OFF    = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = ADDR_WIDTH - OFF;
  localparam int LAT_W  = 16;
  localparam logic [LAT_W-1:0] RD_CNT_END = LAT_W'(RD_LAT - 2);
  localparam logic [LAT_W-1:0] WR_CNT_END = LAT_W'(WR_LAT - 2);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rd_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  wr_state_t            wr_state_reg, wr_state_next;
  logic [ID_WIDTH-1:0]  wr_id_reg, wr_id_next;
  logic [IDX_W-1:0]     wr_idx_reg, wr_idx_next;
  logic [7:0]           wr_len_reg, wr_len_next;
  logic [7:0]           wr_beat_reg, wr_beat_next;
  logic [LAT_W-1:0]     wr_cnt_reg, wr_cnt_next;
  logic                 wr_err_reg, wr_err_next;
  logic                 mem_we;

  rd_state_t            rd_state_reg, rd_state_next;
  logic [ID_WIDTH-1:0]  rd_id_reg, rd_id_next;
  logic [IDX_W-1:0]     rd_idx_reg, rd_idx_next;
  logic [7:0]           rd_len_reg, rd_len_next;
  logic [7:0]           rd_beat_reg, rd_beat_next;
  logic [LAT_W-1:0]     rd_cnt_reg, rd_cnt_next;
  logic                 rd_err_reg, rd_err_next;
  logic                 rd_load;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_err, ar_err;
  logic             unused_inputs;

  assign aw_idx = awaddr_s_inf[OFF +: IDX_W];
  assign ar_idx = araddr_s_inf[OFF +: IDX_W];
  assign unused_inputs = ^{awsize_s_inf, arsize_s_inf, wlast_s_inf, awburst_s_inf,
                           arburst_s_inf, awaddr_s_inf, araddr_s_inf};

`ifdef AXI_MEM_ERR_CHECK_EN
  // Flag non-INCR bursts and bursts whose last word lies at or past DEPTH (no wrap allowed).
  function automatic logic burst_err(input logic [1:0] burst, input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len);
    logic [WORD_W:0] last_word;
    last_word = {1'b0, addr[ADDR_WIDTH-1:OFF]} + {{(WORD_W - 7){1'b0}}, len};
    return (burst != 2'b01) || (last_word >= (WORD_W + 1)'(DEPTH));
  endfunction
  assign aw_err = burst_err(awburst_s_inf, awaddr_s_inf, awlen_s_inf);
  assign ar_err = burst_err(arburst_s_inf, araddr_s_inf, arlen_s_inf);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Write channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      wr_id_reg    <= '0;
      wr_idx_reg   <= '0;
      wr_len_reg   <= '0;
      wr_beat_reg  <= '0;
      wr_cnt_reg   <= '0;
      wr_err_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_id_reg    <= wr_id_next;
      wr_idx_reg   <= wr_idx_next;
      wr_len_reg   <= wr_len_next;
      wr_beat_reg  <= wr_beat_next;
      wr_cnt_reg   <= wr_cnt_next;
      wr_err_reg   <= wr_err_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_id_next    = wr_id_reg;
    wr_idx_next   = wr_idx_reg;
    wr_len_next   = wr_len_reg;
    wr_beat_next  = wr_beat_reg;
    wr_cnt_next   = wr_cnt_reg;
    wr_err_next   = wr_err_reg;
    mem_we        = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (awvalid_s_inf) begin
          wr_state_next = W_DATA;
          wr_id_next    = awid_s_inf;
          wr_idx_next   = aw_idx;
          wr_len_next   = awlen_s_inf;
          wr_beat_next  = '0;
          wr_err_next   = aw_err;
        end
      end
      W_DATA: begin
        if (wvalid_s_inf) begin
          mem_we       = !wr_err_reg;
          wr_idx_next  = wr_idx_reg + 1'b1;
          wr_beat_next = wr_beat_reg + 8'd1;
          // Burst length comes from awlen alone; wlast is not trusted.
          if (wr_beat_reg == wr_len_reg) begin
            wr_state_next = (WR_LAT == 1) ? W_RESP : W_LAT;
            wr_cnt_next   = '0;
          end
        end
      end
      W_LAT: begin
        if (wr_cnt_reg == WR_CNT_END) wr_state_next = W_RESP;
        else                          wr_cnt_next   = wr_cnt_reg + 1'b1;
      end
      W_RESP: begin
        if (bready_s_inf) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign awready_s_inf = (wr_state_reg == W_IDLE) && !rst;
  assign wready_s_inf  = (wr_state_reg == W_DATA);
  assign bvalid_s_inf  = (wr_state_reg == W_RESP);
  assign bid_s_inf     = wr_id_reg;
  assign bresp_s_inf   = (bvalid_s_inf && wr_err_reg) ? 2'b10 : 2'b00;

  // Read channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      rd_id_reg    <= '0;
      rd_idx_reg   <= '0;
      rd_len_reg   <= '0;
      rd_beat_reg  <= '0;
      rd_cnt_reg   <= '0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_id_reg    <= rd_id_next;
      rd_idx_reg   <= rd_idx_next;
      rd_len_reg   <= rd_len_next;
      rd_beat_reg  <= rd_beat_next;
      rd_cnt_reg   <= rd_cnt_next;
      rd_err_reg   <= rd_err_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_id_next    = rd_id_reg;
    rd_idx_next   = rd_idx_reg;
    rd_len_next   = rd_len_reg;
    rd_beat_next  = rd_beat_reg;
    rd_cnt_next   = rd_cnt_reg;
    rd_err_next   = rd_err_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (arvalid_s_inf) begin
          rd_state_next = (RD_LAT == 1) ? R_DATA : R_LAT;
          rd_id_next    = arid_s_inf;
          rd_idx_next   = ar_idx;
          rd_len_next   = arlen_s_inf;
          rd_beat_next  = '0;
          rd_cnt_next   = '0;
          rd_err_next   = ar_err;
        end
      end
      R_LAT: begin
        if (rd_cnt_reg == RD_CNT_END) rd_state_next = R_DATA;
        else                          rd_cnt_next   = rd_cnt_reg + 1'b1;
      end
      R_DATA: begin
        if (rready_s_inf) begin
          if (rd_beat_reg == rd_len_reg) begin
            rd_state_next = R_IDLE;
          end else begin
            rd_idx_next  = rd_idx_reg + 1'b1;
            rd_beat_next = rd_beat_reg + 8'd1;
          end
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Fetch a word only when a new beat is about to be presented, so stalled beats stay frozen
  // even if the write side updates that word meanwhile.
  assign rd_load = (rd_state_next == R_DATA) && !((rd_state_reg == R_DATA) && !rready_s_inf);

  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_idx_reg] <= wdata_s_inf;
    if (rd_load) rdata_reg <= mem[rd_idx_next];
  end

  assign arready_s_inf = (rd_state_reg == R_IDLE) && !rst;
  assign rvalid_s_inf  = (rd_state_reg == R_DATA);
  assign rid_s_inf     = rd_id_reg;
  assign rlast_s_inf   = rvalid_s_inf && (rd_beat_reg == rd_len_reg);
  assign rresp_s_inf   = (rvalid_s_inf && rd_err_reg) ? 2'b10 : 2'b00;
  assign rdata_s_inf   = (rvalid_s_inf && !rd_err_reg) ? rdata_reg : '0;

endmodule

// File: tb/tb_axi4_lat_mem_slave.sv
// Scoreboard bench for axi4_lat_mem_slave: stimulus tasks push expected R/B responses,
// negedge monitors pop and compare them (including first-beat latency).
module tb_axi4_lat_mem_slave;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
`ifdef AXI_MEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   awid = '0, arid = '0, bid, rid;
  logic [31:0]  awaddr = '0, araddr = '0;
  logic [2:0]   awsize = 3'd4, arsize = 3'd4;
  logic [1:0]   awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic [7:0]   awlen = '0, arlen = '0;
  logic         awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic         awready, arready, wready, bvalid, rvalid, rlast;
  logic [127:0] wdata = '0, rdata;

  axi4_lat_mem_slave #(
    .ID_WIDTH(4), .DATA_WIDTH(128), .ADDR_WIDTH(32), .DEPTH(1024), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awsize_s_inf(awsize), .awburst_s_inf(awburst),
    .awlen_s_inf(awlen), .awvalid_s_inf(awvalid), .awready_s_inf(awready),
    .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
    .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
    .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
    .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
    .rvalid_s_inf(rvalid), .rready_s_inf(rready)
  );

  typedef struct {
    logic [3:0]   id;
    logic [127:0] data;
    logic         last;
    logic [1:0]   resp;
    int           cyc;
  } r_exp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
    int         cyc;
  } b_exp_t;

  r_exp_t       r_q[$];
  b_exp_t       b_q[$];
  logic [127:0] wbuf [16];
  logic [127:0] rexp [16];
  int           n_cmp = 0, n_fail = 0, cyc = 0, r_popped = 0;
  int           hs_aw, hs_ar, last_w, c0, base;
  logic         rr_toggle = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(posedge clk); #1; rready = rr_toggle ? ~rready : 1'b1; end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R monitor: a stalled beat stays at the head and is compared again every cycle.
  initial forever begin
    @(negedge clk);
    if (!rst && rvalid) begin
      if (r_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL r_unexpected: actual rvalid=1 rdata=%0h required no beat", rdata);
      end else begin
        r_exp_t e;
        e = r_q[0];
        check("r_beat", 160'({rid, rdata, rlast, rresp}), 160'({e.id, e.data, e.last, e.resp}));
        $display("R beat id=%0h data=%0h last=%0b resp=%0b rready=%0b", rid, rdata, rlast, rresp, rready);
        if (e.cyc >= 0) begin
          check("r_latency", 160'(cyc), 160'(e.cyc));
          e.cyc = -1;
          r_q[0] = e;
        end
        if (rready) begin
          void'(r_q.pop_front());
          r_popped++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && bvalid) begin
      if (b_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected: actual bvalid=1 required no response");
      end else begin
        b_exp_t e;
        e = b_q[0];
        check("b_resp", 160'({bid, bresp}), 160'({e.id, e.resp}));
        $display("B resp id=%0h resp=%0b", bid, bresp);
        if (e.cyc >= 0) check("b_latency", 160'(cyc), 160'(e.cyc));
        if (bready) void'(b_q.pop_front());
      end
    end
  end

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, output int hs);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1; hs = -1;
    for (int i = 0; i < 100 && hs < 0; i++) begin
      @(negedge clk);
      if (awready) hs = cyc;
    end
    tick();
    awvalid = 1'b0;
    if (hs < 0) begin n_cmp++; n_fail++; $display("FAIL aw_timeout: actual awready=0 required 1"); end
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, output int hs);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; hs = -1;
    for (int i = 0; i < 100 && hs < 0; i++) begin
      @(negedge clk);
      if (arready) hs = cyc;
    end
    tick();
    arvalid = 1'b0;
    if (hs < 0) begin n_cmp++; n_fail++; $display("FAIL ar_timeout: actual arready=0 required 1"); end
  endtask

  task automatic w_send(input int n, output int last_hs);
    last_hs = -1;
    for (int b = 0; b < n; b++) begin
      int hs = -1;
      wdata = wbuf[b]; wlast = (b == n - 1); wvalid = 1'b1;
      for (int i = 0; i < 100 && hs < 0; i++) begin
        @(negedge clk);
        if (wready) hs = cyc;
      end
      tick();
      if (hs < 0) begin n_cmp++; n_fail++; $display("FAIL w_timeout: actual wready=0 required 1"); end
      last_hs = hs;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic push_r(input logic [3:0] id, input int n, input logic [1:0] resp, input int first_cyc);
    for (int b = 0; b < n; b++) begin
      r_exp_t e;
      e.id = id; e.data = rexp[b]; e.last = (b == n - 1); e.resp = resp;
      e.cyc = (b == 0) ? first_cyc : -1;
      r_q.push_back(e);
    end
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp, input int exp_cyc);
    b_exp_t e;
    e.id = id; e.resp = resp; e.cyc = exp_cyc;
    b_q.push_back(e);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] resp);
    int hs, last;
    aw_req(id, addr, len, 2'b01, hs);
    w_send(int'(len) + 1, last);
    push_b(id, resp, last + WR_LAT);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] resp);
    int hs;
    ar_req(id, addr, len, burst, hs);
    push_r(id, int'(len) + 1, resp, hs + RD_LAT);
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && i < 300) begin tick(); i++; end
    if (r_q.size() != 0 || b_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: actual %0d R / %0d B pending, required 0", r_q.size(), b_q.size());
      r_q.delete(); b_q.delete();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 160'({awready, arready, wready}), 160'(3'b000));
    check("rst_valid", 160'({bvalid, rvalid, rlast}), 160'(3'b000));
    check("rst_payload", 160'({bid, bresp, rid, rresp, rdata}), 160'(0));
    rst = 1'b0;
    #1;
    check("idle_ready", 160'({awready, arready}), 160'(2'b11));
    tick();

    // Basic write then read, 4 beats at 0x100
    for (int i = 0; i < 4; i++) wbuf[i] = 128'(i + 1);
    write_burst(4'h3, 32'h100, 8'd3, 2'b00);
    wait_drain();
    for (int i = 0; i < 4; i++) rexp[i] = 128'(i + 1);
    read_burst(4'h5, 32'h100, 8'd3, 2'b01, 2'b00);
    wait_drain();

    // Read backpressure, 8 beats with rready toggling
    for (int i = 0; i < 8; i++) wbuf[i] = 128'h10 + 128'(i);
    write_burst(4'h1, 32'h200, 8'd7, 2'b00);
    wait_drain();
    for (int i = 0; i < 8; i++) rexp[i] = 128'h10 + 128'(i);
    rr_toggle = 1'b1;
    read_burst(4'h2, 32'h200, 8'd7, 2'b01, 2'b00);
    wait_drain();
    rr_toggle = 1'b0;
    tick();

    // Wrap from word 1023 to word 0
    wbuf[0] = 128'h55;
    write_burst(4'h4, 32'h0, 8'd0, 2'b00);
    wait_drain();
    wbuf[0] = 128'hA; wbuf[1] = 128'hB;
    write_burst(4'h6, 32'h3FF0, 8'd1, ERR_EN ? 2'b10 : 2'b00);
    wait_drain();
    rexp[0] = ERR_EN ? 128'h0 : 128'hA;
    rexp[1] = ERR_EN ? 128'h0 : 128'hB;
    read_burst(4'h7, 32'h3FF0, 8'd1, 2'b01, ERR_EN ? 2'b10 : 2'b00);
    wait_drain();
    rexp[0] = ERR_EN ? 128'h55 : 128'hB;
    read_burst(4'h8, 32'h0, 8'd0, 2'b01, 2'b00);
    wait_drain();

    // Concurrent AW+AR, write data held back: read sees old word
    wbuf[0] = 128'h77;
    write_burst(4'h7, 32'h300, 8'd0, 2'b00);
    wait_drain();
    c0 = cyc;
    fork
      aw_req(4'h8, 32'h300, 8'd0, 2'b01, hs_aw);
      ar_req(4'h9, 32'h300, 8'd0, 2'b01, hs_ar);
    join
    check("conc_aw_hs", 160'(hs_aw), 160'(c0));
    check("conc_ar_hs", 160'(hs_ar), 160'(c0));
    rexp[0] = 128'h77;
    push_r(4'h9, 1, 2'b00, hs_ar + RD_LAT);
    wait_drain();
    wbuf[0] = 128'h88;
    w_send(1, last_w);
    push_b(4'h8, 2'b00, last_w + WR_LAT);
    wait_drain();

    // Concurrent AW+AR, write lands before the read fetch: read sees new word
    c0 = cyc;
    fork
      aw_req(4'hA, 32'h300, 8'd0, 2'b01, hs_aw);
      ar_req(4'hB, 32'h300, 8'd0, 2'b01, hs_ar);
    join
    check("conc2_aw_hs", 160'(hs_aw), 160'(c0));
    check("conc2_ar_hs", 160'(hs_ar), 160'(c0));
    rexp[0] = 128'h99;
    push_r(4'hB, 1, 2'b00, hs_ar + RD_LAT);
    wbuf[0] = 128'h99;
    w_send(1, last_w);
    push_b(4'hA, 2'b00, last_w + WR_LAT);
    wait_drain();

    // Reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) rexp[i] = 128'h10 + 128'(i);
    base = r_popped;
    read_burst(4'hC, 32'h200, 8'd7, 2'b01, 2'b00);
    for (int i = 0; i < 50 && r_popped < base + 2; i++) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_rvalid", 160'(rvalid), 160'(1'b1));
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 160'({rvalid, rlast, arready, awready, rdata}), 160'(0));
    r_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) rexp[i] = 128'(i + 1);
    read_burst(4'hD, 32'h100, 8'd3, 2'b01, 2'b00);
    wait_drain();

    // Non-INCR burst type
    for (int i = 0; i < 3; i++) rexp[i] = ERR_EN ? 128'h0 : 128'(i + 1);
    read_burst(4'hE, 32'h100, 8'd2, 2'b00, ERR_EN ? 2'b10 : 2'b00);
    wait_drain();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
